stream_mux_arbiter: RTL and testbench

- Packet-mode round-robin arbiter that decides which cell-link input stream owns the shared forwarding mux output.
- Observes per-source TVALID, per-source ARB_REQ_SUPPRESS and the output-side handshake.
- Holds a one-hot grant until the TLAST beat is accepted downstream, or until a watchdog forces release.
- Sits beside the stream mux datapath in the forward cell-link path; drives its select.

---
 rtl/stream_mux_arbiter_pkg.sv | 36 +++
 rtl/stream_mux_arbiter_rr_pick.sv | 26 ++
 rtl/stream_mux_arbiter.sv | 92 +++++++++
 tb/tb_stream_mux_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_arbiter_pkg.sv
// Shared types and helpers for the cell-link stream mux arbiter.
// Supports up to MAX_SRC requesting sources.
package stream_mux_arbiter_pkg;
   localparam int MAX_SRC = 8;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   // Grant index width: clog2(n), never below 1.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // First set bit of req scanning last+1, last+2, ... modulo n.
   function automatic rr_pick_t rr_next(input logic [MAX_SRC-1:0] req, input int last, input int n);
      rr_pick_t r;
      int       idx;
      r = '0;
      for (int k = 1; k <= MAX_SRC; k++) begin
         idx = last + k;
         if (idx >= n) idx = idx - n;
         if (k <= n && !r.found && req[idx[2:0]]) begin
            r.found = 1'b1;
            r.idx   = idx[2:0];
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/stream_mux_arbiter_rr_pick.sv
// Combinational round-robin pick: one-hot winner after last_owner, its index and any_req.
module rr_priority_pick
   import stream_mux_arbiter_pkg::*;
#(
   parameter int NSRC = 2,
   parameter int IW   = 1
) (
   input  logic [NSRC-1:0] req,
   input  logic [IW-1:0]   last_owner,
   output logic [NSRC-1:0] pick,
   output logic [IW-1:0]   pick_idx,
   output logic            any_req
);
   logic [MAX_SRC-1:0] req_ext;
   rr_pick_t           res;

   always_comb begin
      req_ext             = '0;
      req_ext[NSRC-1:0]   = req;
      res                 = rr_next(req_ext, int'(last_owner), NSRC);
      any_req             = res.found;
      pick_idx            = IW'(res.idx);
      pick                = '0;
      if (res.found) pick[pick_idx] = 1'b1;
   end
endmodule

// File: rtl/stream_mux_arbiter.sv
// Packet-mode round-robin arbiter driving the forward cell-link stream mux select.
// Grant is held until TLAST is accepted downstream or the watchdog expires.
module stream_mux_arbiter
   import stream_mux_arbiter_pkg::*;
#(
   parameter int NSRC    = 2,
   parameter int IW      = clog2_min1(NSRC),
   parameter int TIMEOUT = 4096,
   parameter int TW      = 13
) (
   input  logic            aclk,
   input  logic            areset,
   input  logic            arb_enable,
   input  logic [NSRC-1:0] src_tvalid,
   input  logic [NSRC-1:0] src_suppress,
   input  logic            m_tvalid,
   input  logic            m_tready,
   input  logic            m_tlast,
   input  logic            sticky_clr,
   output logic [NSRC-1:0] grant,
   output logic            grant_valid,
   output logic [IW-1:0]   grant_idx,
   output logic            timeout_pulse,
   output logic [NSRC-1:0] timeout_sticky
);
   arb_state_t      state;
   logic [IW-1:0]   last_owner;
   logic [TW-1:0]   tcnt;
   logic [NSRC-1:0] req, pick;
   logic [IW-1:0]   pick_idx;
   logic            any_req, beat, eop, wd_expire;

   assign req       = src_tvalid & ~src_suppress & {NSRC{arb_enable}};
   assign beat      = m_tvalid & m_tready;
   assign eop       = beat & m_tlast;
   assign wd_expire = (tcnt == TW'(TIMEOUT - 1));

   rr_priority_pick #(.NSRC(NSRC), .IW(IW)) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .pick       (pick),
      .pick_idx   (pick_idx),
      .any_req    (any_req)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         state          <= IDLE;
         grant          <= '0;
         grant_valid    <= 1'b0;
         grant_idx      <= '0;
         timeout_pulse  <= 1'b0;
         timeout_sticky <= '0;
         last_owner     <= IW'(NSRC - 1);
         tcnt           <= '0;
      end else begin
         timeout_pulse <= 1'b0;
         // A same-cycle watchdog set below overrides this clear for its bit.
         if (sticky_clr) timeout_sticky <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant       <= pick;
                  grant_idx   <= pick_idx;
                  grant_valid <= 1'b1;
                  last_owner  <= pick_idx;
                  tcnt        <= '0;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (eop || wd_expire) begin
                  grant       <= '0;
                  grant_valid <= 1'b0;
                  grant_idx   <= '0;
                  tcnt        <= '0;
                  state       <= IDLE;
                  if (!eop) begin
                     timeout_pulse             <= 1'b1;
                     timeout_sticky[grant_idx] <= 1'b1;
                  end
               end else if (beat) begin
                  tcnt <= '0;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Scoreboard bench: a packet-level reference model pushes expected outputs each edge,
// a negedge monitor pops and compares them against the arbiter.
module tb_stream_mux_arbiter;
   localparam int NSRC    = 2;
   localparam int IW      = 1;
   localparam int TIMEOUT = 8;
   localparam int TW      = 4;

   logic            aclk = 1'b0;
   logic            areset = 1'b1, arb_enable = 1'b1, sticky_clr = 1'b0;
   logic [NSRC-1:0] src_tvalid = '0, src_suppress = '0;
   logic            m_tvalid = 1'b0, m_tready = 1'b0, m_tlast = 1'b0;
   logic [NSRC-1:0] grant, timeout_sticky;
   logic            grant_valid, timeout_pulse;
   logic [IW-1:0]   grant_idx;

   stream_mux_arbiter #(.NSRC(NSRC), .IW(IW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .arb_enable     (arb_enable),
      .src_tvalid     (src_tvalid),
      .src_suppress   (src_suppress),
      .m_tvalid       (m_tvalid),
      .m_tready       (m_tready),
      .m_tlast        (m_tlast),
      .sticky_clr     (sticky_clr),
      .grant          (grant),
      .grant_valid    (grant_valid),
      .grant_idx      (grant_idx),
      .timeout_pulse  (timeout_pulse),
      .timeout_sticky (timeout_sticky)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [NSRC-1:0] grant;
      logic            gv;
      logic [IW-1:0]   idx;
      logic            pulse;
      logic [NSRC-1:0] sticky;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: owner of the output (-1 = nobody), cycles since progress,
   // and the last granted source for rotation.
   int              owner = -1, rr_last = NSRC - 1, stall = 0, cand, s;
   bit [NSRC-1:0]   sticky_m = '0, nst;
   bit              pulse_m = 1'b0;

   always @(posedge aclk) begin
      exp_t e;
      pulse_m = 1'b0;
      if (areset) begin
         owner = -1; rr_last = NSRC - 1; stall = 0; sticky_m = '0;
      end else begin
         nst = sticky_clr ? '0 : sticky_m;
         if (owner < 0) begin
            cand = -1;
            for (int k = 1; k <= NSRC; k++) begin
               s = (rr_last + k) % NSRC;
               if (cand < 0 && arb_enable && src_tvalid[s] && !src_suppress[s]) cand = s;
            end
            if (cand >= 0) begin owner = cand; rr_last = cand; stall = 0; end
         end else if (m_tvalid && m_tready && m_tlast) begin
            owner = -1;
         end else if (stall == TIMEOUT - 1) begin
            nst[owner] = 1'b1; pulse_m = 1'b1; owner = -1;
         end else if (m_tvalid && m_tready) begin
            stall = 0;
         end else begin
            stall++;
         end
         sticky_m = nst;
      end
      e.grant  = (owner < 0) ? '0 : NSRC'(1 << owner);
      e.gv     = (owner >= 0);
      e.idx    = (owner < 0) ? '0 : IW'(owner);
      e.pulse  = pulse_m;
      e.sticky = sticky_m;
      expq.push_back(e);
   end

   always @(negedge aclk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         check("grant", 32'(grant), 32'(e.grant));
         check("grant_valid", 32'(grant_valid), 32'(e.gv));
         check("grant_idx", 32'(grant_idx), 32'(e.idx));
         check("timeout_pulse", 32'(timeout_pulse), 32'(e.pulse));
         check("timeout_sticky", 32'(timeout_sticky), 32'(e.sticky));
      end
   end

   // Packet source behind the mux: beats only for the current owner.
   int pkt_len = 3, vprob = 100, rprob = 100, bcnt = 0;
   bit manual = 1'b0;

   task automatic step();
      if (!manual) begin
         if (m_tvalid && m_tready) bcnt = m_tlast ? 0 : bcnt + 1;
         if (owner < 0) bcnt = 0;
         m_tvalid = (owner >= 0) && ($urandom_range(99) < vprob);
         m_tready = ($urandom_range(99) < rprob);
         m_tlast  = (bcnt == pkt_len - 1);
      end
      @(posedge aclk); #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      steps(3);
      areset = 1'b0;
      // single source, 3-beat packet
      src_tvalid = 2'b01; pkt_len = 3;
      steps(2);
      src_tvalid = 2'b00;
      steps(6);
      // both sources, 2-beat packets, rotation with one bubble
      src_tvalid = 2'b11; pkt_len = 2;
      steps(12);
      // suppress source 0, release it mid-packet of source 1
      src_suppress = 2'b01; pkt_len = 4;
      steps(5);
      src_suppress = 2'b00;
      steps(10);
      src_tvalid = 2'b00;
      steps(4);
      // watchdog on a stalled packet, then clear the sticky
      src_tvalid = 2'b01; rprob = 0;
      steps(2);
      src_tvalid = 2'b00;
      steps(10);
      sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
      steps(2);
      // eop exactly on the last watchdog cycle
      manual = 1'b1; m_tvalid = 1'b0; m_tready = 1'b0; m_tlast = 1'b0;
      src_tvalid = 2'b01;
      guard = 0;
      while (owner < 0 && guard < 10) begin step(); guard++; end
      check("grant_wait", 32'(owner >= 0), 32'd1);
      src_tvalid = 2'b00;
      steps(TIMEOUT - 1);
      m_tvalid = 1'b1; m_tready = 1'b1; m_tlast = 1'b1;
      step();
      m_tvalid = 1'b0; m_tlast = 1'b0;
      steps(3);
      manual = 1'b0; rprob = 100;
      // reset mid-packet, then both valid: source 0 first
      src_tvalid = 2'b11; pkt_len = 5;
      steps(4);
      areset = 1'b1; step(); areset = 1'b0;
      steps(10);
      // randomized traffic
      vprob = 70; rprob = 70;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rprob = ($urandom_range(3) == 0) ? 0 : 70;
         if (owner < 0) pkt_len = $urandom_range(1, 4);
         src_tvalid   = NSRC'($urandom);
         src_suppress = ($urandom_range(3) == 0) ? NSRC'($urandom) : '0;
         arb_enable   = ($urandom_range(9) != 0);
         sticky_clr   = ($urandom_range(19) == 0);
         areset       = ($urandom_range(299) == 0);
         step();
      end
      areset = 1'b0; sticky_clr = 1'b0; src_tvalid = '0;
      steps(3);
      @(negedge aclk); #1;
      check("queue_drain", 32'(expq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
